// File: rtl/b8to64_pkg.sv
// Shared field layout and FSM encoding for the 64-bit sextet word format,
// used by both the ADC sextet packer and the frame unpacker.
package b8to64_pkg;

    localparam int ADC_SEL_BIT    = 63;
    localparam int HALF_SHIFT_BIT = 62;
    localparam int SWITCHER_BIT   = 61;
    localparam int SEXTET_MSB     = 60;
    localparam int SEXTET_LSB     = 48;
    localparam int BYTES_PER_WORD = 6;

    localparam logic [2:0] LAST_BYTE_IDX = 3'(BYTES_PER_WORD - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        CHECK,
        EMIT
    } state_e;

    // Byte 0 is the oldest sample and sits in the low bits of the payload.
    function automatic logic [7:0] payload_byte(input logic [47:0] payload,
                                                input logic [2:0]  idx);
        logic [7:0] b;
        case (idx)
            3'd0:    b = payload[7:0];
            3'd1:    b = payload[15:8];
            3'd2:    b = payload[23:16];
            3'd3:    b = payload[31:24];
            3'd4:    b = payload[39:32];
            3'd5:    b = payload[47:40];
            default: b = payload[7:0];
        endcase
        return b;
    endfunction

endpackage

// File: rtl/b64to8_frame_unpacker_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            cnt_q <= '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/b64to8_frame_unpacker.sv
// Pops packed 64-bit sextet words, tracks frame sequence against the
// configured length and streams the six samples out as bytes.
module b64to8_frame_unpacker
    import b8to64_pkg::*;
#(
    parameter int FRAME_LEN_W = 13,
    parameter int FRAME_CNT_W = 24,
    parameter int ERR_CNT_W   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fifo_empty,
    output logic                   fifo_rd_en,
    input  logic [63:0]            fifo_dout,
    input  logic [FRAME_LEN_W-1:0] frame_length,
    output logic [7:0]             byte_out,
    output logic                   byte_valid,
    input  logic                   byte_ready,
    output logic                   byte_sof,
    output logic                   byte_eof,
    output logic [2:0]             hdr_flags,
    output logic                   in_sync,
    output logic                   seq_err,
    output logic                   frame_abort,
    output logic                   switch_evt,
    output logic [FRAME_CNT_W-1:0] frame_cnt,
    output logic [ERR_CNT_W-1:0]   err_cnt,
    output logic [ERR_CNT_W-1:0]   drop_cnt
);

    state_e                 state_q, state_d;
    logic [63:0]            word_q, word_d;
    logic [2:0]             idx_q, idx_d;
    logic                   in_sync_q, in_sync_d;
    logic [FRAME_LEN_W-1:0] exp_q, exp_d;
    logic [FRAME_LEN_W-1:0] len_q, len_d;
    logic                   prev_sw_q, prev_sw_d;
    logic                   first_q, first_d;
    logic                   sof_q, sof_d;
    logic                   eof_q, eof_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic [FRAME_LEN_W-1:0] sextet;
    logic                   switcher;
    logic                   rd_req;
    logic                   restart;
    logic                   err_inc;
    logic                   drop_inc;

    assign sextet   = word_q[SEXTET_MSB:SEXTET_LSB];
    assign switcher = word_q[SWITCHER_BIT];

    always_comb begin
        state_d     = state_q;
        word_d      = word_q;
        idx_d       = idx_q;
        in_sync_d   = in_sync_q;
        exp_d       = exp_q;
        len_d       = len_q;
        prev_sw_d   = prev_sw_q;
        first_d     = first_q;
        sof_d       = sof_q;
        eof_d       = eof_q;
        frame_cnt_d = frame_cnt_q;
        rd_req      = 1'b0;
        restart     = 1'b0;
        seq_err     = 1'b0;
        frame_abort = 1'b0;
        switch_evt  = 1'b0;
        err_inc     = 1'b0;
        drop_inc    = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    rd_req  = 1'b1;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                word_d  = fifo_dout;
                state_d = CHECK;
            end
            CHECK: begin
                // NOTE: the event pulses are decoded from CHECK itself, which lasts exactly one cycle.
                seq_err     = in_sync_q && (sextet != exp_q);
                frame_abort = seq_err;
                err_inc     = seq_err;
                restart     = (sextet == '0) && (!in_sync_q || seq_err);
                idx_d       = '0;
                if (restart) begin
                    in_sync_d  = 1'b1;
                    len_d      = frame_length;
                    exp_d      = FRAME_LEN_W'(1);
                    sof_d      = 1'b1;
                    eof_d      = (frame_length == '0);
                    prev_sw_d  = switcher;
                    first_d    = 1'b0;
                    switch_evt = !first_q && (switcher != prev_sw_q);
                    state_d    = EMIT;
                end else if (in_sync_q && !seq_err) begin
                    exp_d   = exp_q + FRAME_LEN_W'(1);
                    sof_d   = 1'b0;
                    eof_d   = (sextet == len_q);
                    state_d = EMIT;
                end else begin
                    drop_inc  = 1'b1;
                    in_sync_d = 1'b0;
                    exp_d     = '0;
                    state_d   = IDLE;
                end
            end
            EMIT: begin
                if (byte_ready) begin
                    if (idx_q == LAST_BYTE_IDX) begin
                        idx_d   = '0;
                        state_d = IDLE;
                        if (eof_q) begin
                            frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
                            in_sync_d   = 1'b0;
                            exp_d       = '0;
                        end
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the data word is reset along with the control state so byte_out and hdr_flags read 0 out of reset.
        if (rst) begin
            state_q     <= IDLE;
            word_q      <= '0;
            idx_q       <= '0;
            in_sync_q   <= 1'b0;
            exp_q       <= '0;
            len_q       <= '0;
            prev_sw_q   <= 1'b0;
            first_q     <= 1'b1;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            word_q      <= word_d;
            idx_q       <= idx_d;
            in_sync_q   <= in_sync_d;
            exp_q       <= exp_d;
            len_q       <= len_d;
            prev_sw_q   <= prev_sw_d;
            first_q     <= first_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    sat_counter #(.W(ERR_CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .inc_i (err_inc),
        .cnt_o (err_cnt)
    );

    sat_counter #(.W(ERR_CNT_W)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .inc_i (drop_inc),
        .cnt_o (drop_cnt)
    );

    // The read strobe pops the FIFO, so it must stay quiet while reset is held.
    assign fifo_rd_en = rd_req && !rst;
    assign byte_valid = (state_q == EMIT);
    assign byte_out   = payload_byte(word_q[47:0], idx_q);
    assign byte_sof   = byte_valid && sof_q && (idx_q == '0);
    assign byte_eof   = byte_valid && eof_q && (idx_q == LAST_BYTE_IDX);
    assign hdr_flags  = {word_q[ADC_SEL_BIT], word_q[HALF_SHIFT_BIT], word_q[SWITCHER_BIT]};
    assign in_sync    = in_sync_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_b64to8_frame_unpacker.sv
// Directed bench for the frame unpacker: FIFO model, byte collector and
// hand-computed expectations for sync, errors, backpressure and reset.
module tb_b64to8_frame_unpacker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [63:0] fifo_dout = '0;
    logic [12:0] frame_length = '0;
    logic [7:0]  byte_out;
    logic        byte_valid;
    logic        byte_ready = 1'b1;
    logic        byte_sof;
    logic        byte_eof;
    logic [2:0]  hdr_flags;
    logic        in_sync;
    logic        seq_err;
    logic        frame_abort;
    logic        switch_evt;
    logic [23:0] frame_cnt;
    logic [15:0] err_cnt;
    logic [15:0] drop_cnt;

    always #5 clk = ~clk;

    b64to8_frame_unpacker dut (
        .clk          (clk),
        .rst          (rst),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_dout    (fifo_dout),
        .frame_length (frame_length),
        .byte_out     (byte_out),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .byte_sof     (byte_sof),
        .byte_eof     (byte_eof),
        .hdr_flags    (hdr_flags),
        .in_sync      (in_sync),
        .seq_err      (seq_err),
        .frame_abort  (frame_abort),
        .switch_evt   (switch_evt),
        .frame_cnt    (frame_cnt),
        .err_cnt      (err_cnt),
        .drop_cnt     (drop_cnt)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // FIFO model: registered read data, one cycle after the strobe.
    logic [63:0] fifo_mem [0:255];
    int          wr_ptr = 0;
    int          rd_ptr = 0;

    assign fifo_empty = (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_dout <= fifo_mem[rd_ptr];
            rd_ptr    <= rd_ptr + 1;
        end
    end

    logic rand_ready = 1'b0;

    always @(posedge clk) begin
        #1;
        byte_ready = rand_ready ? ($urandom_range(0, 9) >= 3) : 1'b1;
    end

    // Collector and event monitor, sampled on the falling edge.
    logic [7:0] rx_byte  [0:511];
    logic       rx_sof   [0:511];
    logic       rx_eof   [0:511];
    logic [2:0] rx_flags [0:511];
    int         n_rx = 0;
    int         n_seq = 0;
    int         n_abort = 0;
    int         n_sw = 0;
    int         n_sync_rise = 0;
    logic       prev_sync = 1'b0;
    logic       prev_stall = 1'b0;
    logic [7:0] snap_byte;
    logic       snap_sof;
    logic       snap_eof;
    logic [2:0] snap_flags;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
            prev_sync  <= 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", byte_valid, 1);
                check("stall_byte", byte_out, snap_byte);
                check("stall_sof", byte_sof, snap_sof);
                check("stall_eof", byte_eof, snap_eof);
                check("stall_flags", hdr_flags, snap_flags);
            end
            if (fifo_rd_en) check("rd_en_while_empty", fifo_empty, 0);
            if (byte_valid && byte_ready) begin
                rx_byte[n_rx]  <= byte_out;
                rx_sof[n_rx]   <= byte_sof;
                rx_eof[n_rx]   <= byte_eof;
                rx_flags[n_rx] <= hdr_flags;
                n_rx           <= n_rx + 1;
            end
            prev_stall <= byte_valid && !byte_ready;
            snap_byte  <= byte_out;
            snap_sof   <= byte_sof;
            snap_eof   <= byte_eof;
            snap_flags <= hdr_flags;
            if (seq_err)     n_seq   <= n_seq + 1;
            if (frame_abort) n_abort <= n_abort + 1;
            if (switch_evt)  n_sw    <= n_sw + 1;
            if (in_sync && !prev_sync) n_sync_rise <= n_sync_rise + 1;
            prev_sync <= in_sync;
        end
    end

    task automatic push(input logic [12:0] s, input logic [2:0] fl, input logic [7:0] base);
        logic [47:0] p;
        for (int j = 0; j < 6; j++) p[j*8 +: 8] = base + 8'(j);
        fifo_mem[wr_ptr] = {fl, s, p};
        wr_ptr++;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drain(input string tag);
        int quiet = 0;
        int cyc   = 0;
        while (quiet < 12 && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (fifo_empty && !byte_valid) quiet++;
            else quiet = 0;
        end
        check({tag, "_drain"}, quiet >= 12, 1);
    endtask

    task automatic count_marks(input int start, input int n, output int sofs, output int eofs);
        sofs = 0;
        eofs = 0;
        for (int i = 0; i < n; i++) begin
            if (rx_sof[start+i]) sofs++;
            if (rx_eof[start+i]) eofs++;
        end
    endtask

    initial begin
        int base, d_seq, d_abort, d_sw, d_rise, sofs, eofs, cyc;

        // Reset state.
        do_reset();
        check("rst_valid", byte_valid, 0);
        check("rst_byte", byte_out, 0);
        check("rst_flags", hdr_flags, 0);
        check("rst_sync", in_sync, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_err_cnt", err_cnt, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        check("rst_rd_en", fifo_rd_en, 0);

        // 1: clean three-word frame, L=2.
        frame_length = 13'd2;
        base = n_rx;
        push(13'd0, 3'b000, 8'h00);
        push(13'd1, 3'b101, 8'h06);
        push(13'd2, 3'b010, 8'h0c);
        drain("t1");
        check("t1_nbytes", n_rx - base, 18);
        for (int i = 0; i < 18; i++) check("t1_byte", rx_byte[base+i], 64'(i));
        check("t1_sof_first", rx_sof[base], 1);
        check("t1_eof_last", rx_eof[base+17], 1);
        count_marks(base, 18, sofs, eofs);
        check("t1_sof_count", sofs, 1);
        check("t1_eof_count", eofs, 1);
        check("t1_flags_w1", rx_flags[base+6], 3'b101);
        check("t1_flags_w1_end", rx_flags[base+11], 3'b101);
        check("t1_flags_w2", rx_flags[base+12], 3'b010);
        check("t1_frame_cnt", frame_cnt, 1);
        check("t1_err_cnt", err_cnt, 0);
        check("t1_drop_cnt", drop_cnt, 0);
        check("t1_unsynced_after_eof", in_sync, 0);

        // 2: unsynced words dropped until sextet 0.
        do_reset();
        base = n_rx;
        d_rise = n_sync_rise;
        push(13'd3, 3'b000, 8'h40);
        push(13'd4, 3'b000, 8'h50);
        push(13'd0, 3'b000, 8'h00);
        push(13'd1, 3'b000, 8'h06);
        push(13'd2, 3'b000, 8'h0c);
        drain("t2");
        check("t2_drop_cnt", drop_cnt, 2);
        check("t2_err_cnt", err_cnt, 0);
        check("t2_sync_rise", n_sync_rise - d_rise, 1);
        check("t2_nbytes", n_rx - base, 18);
        check("t2_first_byte", rx_byte[base], 8'h00);
        check("t2_last_byte", rx_byte[base+17], 8'h11);
        check("t2_frame_cnt", frame_cnt, 1);

        // 3: gap to a non-zero sextet aborts and drops.
        do_reset();
        frame_length = 13'd5;
        base = n_rx;
        d_seq = n_seq;
        d_abort = n_abort;
        push(13'd0, 3'b000, 8'h20);
        push(13'd1, 3'b000, 8'h26);
        push(13'd3, 3'b000, 8'h2c);
        drain("t3");
        check("t3_seq_err", n_seq - d_seq, 1);
        check("t3_abort", n_abort - d_abort, 1);
        check("t3_err_cnt", err_cnt, 1);
        check("t3_drop_cnt", drop_cnt, 1);
        check("t3_nbytes", n_rx - base, 12);
        count_marks(base, 12, sofs, eofs);
        check("t3_eof_count", eofs, 0);
        check("t3_frame_cnt", frame_cnt, 0);
        check("t3_sync", in_sync, 0);

        // 4: unexpected sextet 0 restarts the frame.
        do_reset();
        frame_length = 13'd2;
        base = n_rx;
        d_seq = n_seq;
        d_abort = n_abort;
        push(13'd0, 3'b000, 8'h00);
        push(13'd1, 3'b000, 8'h06);
        push(13'd0, 3'b000, 8'h0c);
        push(13'd1, 3'b000, 8'h12);
        push(13'd2, 3'b000, 8'h18);
        drain("t4");
        check("t4_seq_err", n_seq - d_seq, 1);
        check("t4_abort", n_abort - d_abort, 1);
        check("t4_err_cnt", err_cnt, 1);
        check("t4_drop_cnt", drop_cnt, 0);
        check("t4_nbytes", n_rx - base, 30);
        check("t4_sof_restart", rx_sof[base+12], 1);
        check("t4_eof_pos", rx_eof[base+29], 1);
        count_marks(base, 30, sofs, eofs);
        check("t4_sof_count", sofs, 2);
        check("t4_eof_count", eofs, 1);
        check("t4_frame_cnt", frame_cnt, 1);

        // 5: four L=7 frames under random backpressure.
        do_reset();
        frame_length = 13'd7;
        base = n_rx;
        for (int f = 0; f < 4; f++)
            for (int w = 0; w < 8; w++)
                push(13'(w), 3'b000, 8'((f*8 + w) * 6));
        rand_ready = 1'b1;
        drain("t5");
        rand_ready = 1'b0;
        check("t5_nbytes", n_rx - base, 192);
        for (int i = 0; i < 192; i++) begin
            check("t5_byte", rx_byte[base+i], 64'(i % 256));
            check("t5_sof", rx_sof[base+i], (i % 48) == 0);
            check("t5_eof", rx_eof[base+i], (i % 48) == 47);
        end
        check("t5_frame_cnt", frame_cnt, 4);
        check("t5_err_cnt", err_cnt, 0);
        check("t5_drop_cnt", drop_cnt, 0);

        // 6: single-word frames (L=0) and switcher tracking.
        do_reset();
        frame_length = 13'd0;
        base = n_rx;
        d_sw = n_sw;
        push(13'd0, 3'b001, 8'h80);
        drain("t6a");
        check("t6_first_frame_no_switch", n_sw - d_sw, 0);
        check("t6_single_sof", rx_sof[base], 1);
        check("t6_single_eof", rx_eof[base+5], 1);
        push(13'd0, 3'b000, 8'h90);
        drain("t6b");
        check("t6_switch_once", n_sw - d_sw, 1);
        push(13'd0, 3'b000, 8'ha0);
        drain("t6c");
        check("t6_no_switch_same", n_sw - d_sw, 1);
        check("t6_frame_cnt", frame_cnt, 3);

        // 7: reset in the middle of a word.
        frame_length = 13'd2;
        push(13'd0, 3'b000, 8'h00);
        cyc = 0;
        while (!byte_valid && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("t7_reached_emit", byte_valid, 1);
        @(negedge clk);
        check("t7_synced", in_sync, 1);
        rst = 1'b1;
        @(negedge clk);
        check("t7_valid_dropped", byte_valid, 0);
        check("t7_frame_cnt", frame_cnt, 0);
        check("t7_err_cnt", err_cnt, 0);
        check("t7_drop_cnt", drop_cnt, 0);
        check("t7_sync", in_sync, 0);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/b64to8_frame_unpacker.md
Name: b64to8_frame_unpacker

Overview:
Reader-side counterpart of the ADC sextet packer. Pops 64-bit packed words from the acquisition FIFO and checks the 13-bit sextet sequence against the configured frame length. Emits the six ADC samples as a byte stream with a valid/ready handshake, start-of-frame and end-of-frame markers, and per-word header flags. Sits between the FIFO read port and downstream averaging/readout logic, all in the `clk` domain.

Parameters:
FRAME_LEN_W, 13, width of sextet counter and frame length.
FRAME_CNT_W, 24, width of accepted-frame counter.
ERR_CNT_W, 16, width of saturating error/drop counters.

Ports:
clk  in  1  system clock; the only clock.
rst  in  1  synchronous, active-high reset.
fifo_empty  in  1  FIFO empty flag.
fifo_rd_en  out  1  FIFO read strobe; data is valid one cycle later.
fifo_dout  in  64  packed word: [63]=adc_sel, [62]=half_shift, [61]=switcher, [60:48]=sextet, [47:0]=bytes 5..0 (byte0 = [7:0] = oldest sample).
frame_length  in  13  last sextet index of a frame (CONFIG_REG_1[12:0]).
byte_out  out  8  sample byte.
byte_valid  out  1  byte_out valid.
byte_ready  in  1  downstream accepts when valid&ready.
byte_sof  out  1  with first byte of a frame (sextet 0, byte0).
byte_eof  out  1  with last byte of a frame (sextet==latched length, byte5).
hdr_flags  out  3  {adc_sel, half_shift, switcher} of the current word, held for its 6 bytes.
in_sync  out  1  1 while locked to a frame.
seq_err  out  1  one-cycle pulse on a sequence mismatch.
frame_abort  out  1  one-cycle pulse when a frame ends without eof.
switch_evt  out  1  one-cycle pulse when a new frame's switcher bit differs from the previous frame's.
frame_cnt  out  24  completed frames, wraps.
err_cnt  out  16  seq errors, saturating.
drop_cnt  out  16  words discarded while unsynced, saturating.

Behaviour:
- Reset: all outputs 0. State IDLE, unsynced, expected sextet 0, previous switcher 0, "first frame" flag set.
- FSM states:
  - IDLE: if !fifo_empty, assert fifo_rd_en for 1 cycle and go to WAIT.
  - WAIT: capture fifo_dout at end of cycle, then go to CHECK.
  - CHECK: evaluate the word for 1 cycle, then go to EMIT, or back to IDLE if the word is dropped.
  - EMIT: present bytes 0..5 in order; advance the index only on valid&ready. After byte5 is accepted, go to IDLE.
- Throughput: at most 1 word per 9 cycles with ready held high. No prefetch.
- fifo_rd_en is never asserted when fifo_empty is 1, and never outside IDLE.
- CHECK rules (s = word sextet):
  - Unsynced, s==0: enter sync, latch frame_length as L, expected=1, mark byte0 sof.
  - Unsynced, s!=0: drop the word, drop_cnt++.
  - Synced, s==expected: accept; expected++.
  - Synced, s!=expected: seq_err pulse, err_cnt++.
    - If s==0: frame_abort pulse, restart as in the unsynced s==0 case.
    - Otherwise: frame_abort pulse, go unsynced, drop the word (drop_cnt++).
- Accepted word with s==L: byte5 carries byte_eof. When byte5 is accepted: frame_cnt++, expected=0, go unsynced so the next word must be 0.
- If L==0, a single word carries both sof (byte0) and eof (byte5).
- frame_length is sampled only at sof; changes mid-frame take effect on the next frame.
- switch_evt pulses in CHECK at sof when switcher != the previous frame's switcher, suppressed for the first frame after reset. The previous-frame switcher register updates at each sof.
- byte_out, byte_sof, byte_eof and hdr_flags stay stable while valid && !ready.
- Counters: err_cnt and drop_cnt saturate at all-ones. frame_cnt wraps at 2^24.
- Reset mid-EMIT: byte_valid drops the next cycle and the partially emitted word is discarded.

Decomposition:
- Package b8to64_pkg holds:
  - word field bit positions (ADC_SEL_BIT=63, HALF_SHIFT_BIT=62, SWITCHER_BIT=61, SEXTET_MSB=60, SEXTET_LSB=48);
  - BYTES_PER_WORD=6;
  - FSM state enum {IDLE, WAIT, CHECK, EMIT}.
- The packer is updated to use the same package constants.
- One sub-module, sat_counter (parameterised width, inc, sync clear), instantiated for err_cnt and drop_cnt.

Test Plan:
- L=2; push words with sextet 0,1,2, bytes 0x00..0x11, ready=1 -> 18 bytes in order 0x00..0x11; sof on byte 0x00; eof on 0x11; frame_cnt=1; no errors.
- After reset, push sextet 3,4 then 0,1,2 (L=2) -> drop_cnt=2, in_sync rises at sextet-0 CHECK, one full frame emitted.
- Synced, push 0,1,3 (L=5) -> seq_err and frame_abort pulse once each, err_cnt=1, word 3 dropped (drop_cnt=1), no eof emitted.
- Synced, push 0,1,0,1,2 (L=2) -> seq_err at the second 0, which restarts a frame with sof; eof at 2; frame_cnt=1.
- Random byte_ready backpressure (30% low) over 4 frames with L=7 -> byte stream identical to the ready=1 run; outputs stable while stalled; fifo_rd_en never high while fifo_empty.
- Two frames with switcher 0 then 1 -> switch_evt pulses exactly once, at the second sof; assert rst mid-EMIT -> byte_valid 0 and all counters 0 next cycle.
